tap_controller: RTL and testbench

//  IEEE 1149.1 16-state TAP controller FSM, advanced by TMS on each TCK rising edge.

---
 rtl/tap_controller.sv | 102 ++++++++++
 tb/tb_tap_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state Moore FSM clocked by TCK.
// Decodes IR/DR strobes, the TDO mux select and the TDO enable from the state register.
module tap_controller (
  input  logic       TCK,
  input  logic       Reset,
  input  logic       TMS,
  output logic [3:0] State,
  output logic       TapReset,
  output logic       ShiftIR,
  output logic       ClockIR,
  output logic       UpdateIR,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Select,
  output logic       Enable
);

  // state   | meaning
  // TLR     | test-logic-reset, IR/DR held in reset
  // RTI     | run-test/idle
  // SELDR   | select DR column
  // CAPDR   | DR parallel capture
  // SHDR    | DR shift, TDO enabled
  // EX1DR   | exit1 DR
  // PAUSEDR | DR shift paused, contents held
  // EX2DR   | exit2 DR
  // UPDDR   | DR update latch loads
  // SELIR   | select IR column
  // CAPIR   | IR parallel capture
  // SHIR    | IR shift, TDO enabled
  // EX1IR   | exit1 IR
  // PAUSEIR | IR shift paused, contents held
  // EX2IR   | exit2 IR
  // UPDIR   | IR update latch loads
  typedef enum logic [3:0] {
    TLR     = 4'hF,
    RTI     = 4'hC,
    SELDR   = 4'h7,
    CAPDR   = 4'h6,
    SHDR    = 4'h2,
    EX1DR   = 4'h1,
    PAUSEDR = 4'h3,
    EX2DR   = 4'h0,
    UPDDR   = 4'h5,
    SELIR   = 4'h4,
    CAPIR   = 4'hE,
    SHIR    = 4'hA,
    EX1IR   = 4'h9,
    PAUSEIR = 4'hB,
    EX2IR   = 4'h8,
    UPDIR   = 4'hD
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge TCK) begin
    if (Reset) r_state <= TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = TLR;
    case (r_state)
      TLR:     w_next = TMS ? TLR     : RTI;
      RTI:     w_next = TMS ? SELDR   : RTI;
      SELDR:   w_next = TMS ? SELIR   : CAPDR;
      CAPDR:   w_next = TMS ? EX1DR   : SHDR;
      SHDR:    w_next = TMS ? EX1DR   : SHDR;
      EX1DR:   w_next = TMS ? UPDDR   : PAUSEDR;
      PAUSEDR: w_next = TMS ? EX2DR   : PAUSEDR;
      EX2DR:   w_next = TMS ? UPDDR   : SHDR;
      UPDDR:   w_next = TMS ? SELDR   : RTI;
      SELIR:   w_next = TMS ? TLR     : CAPIR;
      CAPIR:   w_next = TMS ? EX1IR   : SHIR;
      SHIR:    w_next = TMS ? EX1IR   : SHIR;
      EX1IR:   w_next = TMS ? UPDIR   : PAUSEIR;
      PAUSEIR: w_next = TMS ? EX2IR   : PAUSEIR;
      EX2IR:   w_next = TMS ? UPDIR   : SHIR;
      UPDIR:   w_next = TMS ? SELDR   : RTI;
      default: w_next = TLR;
    endcase
  end

  // Outputs depend on the state register only; TMS never reaches them combinationally.
  always_comb begin
    State    = r_state;
    TapReset = (r_state == TLR);
    ShiftIR  = (r_state == SHIR);
    ClockIR  = (r_state == CAPIR) || (r_state == SHIR);
    UpdateIR = (r_state == UPDIR);
    ShiftDR  = (r_state == SHDR);
    ClockDR  = (r_state == CAPDR) || (r_state == SHDR);
    UpdateDR = (r_state == UPDDR);
    Select   = (r_state == SELIR) || (r_state == CAPIR) || (r_state == SHIR) ||
               (r_state == EX1IR) || (r_state == PAUSEIR) || (r_state == EX2IR) ||
               (r_state == UPDIR);
    Enable   = (r_state == SHIR) || (r_state == SHDR);
  end

endmodule

// File: tb/tb_tap_controller.sv
// Directed and table-driven random checks for the TAP controller state sequence and strobes.
module tb_tap_controller;

  logic       TCK = 1'b0;
  logic       Reset = 1'b0;
  logic       TMS = 1'b0;
  logic [3:0] State;
  logic       TapReset, ShiftIR, ClockIR, UpdateIR;
  logic       ShiftDR, ClockDR, UpdateDR, Select, Enable;
  logic [8:0] w_outs;

  int n_checks = 0;
  int n_errors = 0;
  int n_clkir, n_shir, n_updir, n_clkdr, n_updr, n_en, n_sel;
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];

  tap_controller dut (
    .TCK(TCK), .Reset(Reset), .TMS(TMS), .State(State),
    .TapReset(TapReset), .ShiftIR(ShiftIR), .ClockIR(ClockIR), .UpdateIR(UpdateIR),
    .ShiftDR(ShiftDR), .ClockDR(ClockDR), .UpdateDR(UpdateDR),
    .Select(Select), .Enable(Enable)
  );

  always #5 TCK = ~TCK;

  assign w_outs = {TapReset, ShiftIR, ClockIR, UpdateIR, ShiftDR, ClockDR, UpdateDR, Select, Enable};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_outs(input logic [3:0] s);
    logic sel;
    sel = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
          (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
    return {s == 4'hF, s == 4'hA, (s == 4'hE) || (s == 4'hA), s == 4'hD,
            s == 4'h2, (s == 4'h6) || (s == 4'h2), s == 4'h5, sel,
            (s == 4'hA) || (s == 4'h2)};
  endfunction

  task automatic clr_counts();
    n_clkir = 0; n_shir = 0; n_updir = 0; n_clkdr = 0; n_updr = 0; n_en = 0; n_sel = 0;
  endtask

  task automatic step(input logic tms, input logic rst, input logic [3:0] es, input string tag);
    TMS = tms;
    Reset = rst;
    @(posedge TCK);
    #1;
    chk({tag, "_state"}, {28'd0, State}, {28'd0, es});
    chk({tag, "_outs"}, {23'd0, w_outs}, {23'd0, exp_outs(es)});
    chk({tag, "_excl"}, 32'($countones({ClockIR, ClockDR, UpdateIR, UpdateDR}) <= 1), 32'd1);
    n_clkir += int'(ClockIR);
    n_shir  += int'(ShiftIR);
    n_updir += int'(UpdateIR);
    n_clkdr += int'(ClockDR);
    n_updr  += int'(UpdateDR);
    n_en    += int'(Enable);
    n_sel   += int'(Select);
  endtask

  initial begin
    logic [7:0]  tms2;
    logic [31:0] st2;
    logic [11:0] tms3;
    logic [47:0] st3;
    logic [3:0]  cur, es;
    logic        t, r;

    nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
    nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
    nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
    nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
    nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
    nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
    nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
    nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
    nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
    nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
    nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
    nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
    nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
    nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
    nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
    nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;

    #2;
    // 1: reset with TMS high, then leave to RTI
    step(1'b1, 1'b1, 4'hF, "t1_rst");
    step(1'b1, 1'b0, 4'hF, "t1_hold");
    step(1'b0, 1'b0, 4'hC, "t1_rti");

    // 2: IR scan
    clr_counts();
    tms2 = 8'b0110_0011;
    st2  = 32'hCD9AAE47;
    for (int i = 0; i < 8; i++) step(tms2[i], 1'b0, st2[4*i +: 4], "t2_ir");
    chk("t2_clockir_cycles", n_clkir, 3);
    chk("t2_shiftir_cycles", n_shir, 2);
    chk("t2_updateir_cycles", n_updir, 1);
    chk("t2_select_cycles", n_sel, 6);

    // 3: DR scan with pause
    clr_counts();
    tms3 = 12'h691;
    st3  = 48'hC51203312267;
    for (int i = 0; i < 12; i++) step(tms3[i], 1'b0, st3[4*i +: 4], "t3_dr");
    chk("t3_enable_cycles", n_en, 3);
    chk("t3_clockdr_cycles", n_clkdr, 4);
    chk("t3_updatedr_cycles", n_updr, 1);
    chk("t3_clockir_cycles", n_clkir, 0);

    // 4: five TMS=1 edges from SHDR
    step(1'b1, 1'b0, 4'h7, "t4_pre");
    step(1'b0, 1'b0, 4'h6, "t4_pre");
    step(1'b0, 1'b0, 4'h2, "t4_pre");
    clr_counts();
    step(1'b1, 1'b0, 4'h1, "t4_e1");
    chk("t4_no_early_upd", n_updr, 0);
    step(1'b1, 1'b0, 4'h5, "t4_e2");
    step(1'b1, 1'b0, 4'h7, "t4_e3");
    step(1'b1, 1'b0, 4'h4, "t4_e4");
    step(1'b1, 1'b0, 4'hF, "t4_e5");
    chk("t4_updatedr_cycles", n_updr, 1);
    chk("t4_tapreset", {31'd0, TapReset}, 1);

    // 5: reset in SHIR aborts shift with no update
    step(1'b0, 1'b0, 4'hC, "t5_pre");
    step(1'b1, 1'b0, 4'h7, "t5_pre");
    step(1'b1, 1'b0, 4'h4, "t5_pre");
    step(1'b0, 1'b0, 4'hE, "t5_pre");
    clr_counts();
    step(1'b0, 1'b0, 4'hA, "t5_shir");
    step(1'b1, 1'b1, 4'hF, "t5_rst");
    step(1'b1, 1'b0, 4'hF, "t5_hold");
    chk("t5_updateir_cycles", n_updir, 0);
    chk("t5_tapreset", {31'd0, TapReset}, 1);

    // 6: random TMS with occasional reset against the transition table
    cur = 4'hF;
    for (int i = 0; i < 10000; i++) begin
      t = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 63) == 0);
      es = r ? 4'hF : (t ? nx1[cur] : nx0[cur]);
      step(t, r, es, "t6_rand");
      cur = es;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
